// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM entry by entry, holding each note for its beats and ending it with a silent gap
module song_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int NUM_SONGS   = 4,
  parameter int SONG_ADDR_W = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  input  logic                                     play_pause,
  input  logic                                     next_song,
  input  logic                                     prev_song,
  output logic [$clog2(NUM_SONGS)+SONG_ADDR_W-1:0] rom_addr,
  input  logic [15:0]                              rom_data,
  output logic [9:0]                               note,
  output logic [$clog2(NUM_SONGS)-1:0]             song_idx,
  output logic                                     playing,
  output logic                                     done
);
  localparam int SW = $clog2(NUM_SONGS);
  localparam int BW = $clog2(BEAT_CYCLES);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE} state_t;
  state_t state_q, state_d, saved_q, saved_d;
  logic [SW-1:0] song_q, song_d;
  logic [SONG_ADDR_W-1:0] offset_q, offset_d;
  logic [9:0] note_q, note_d, ent_q, ent_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [5:0] dur_q, dur_d;
  logic beat_wrap, last_off, end_mark;
  assign beat_wrap = beat_q == BW'(BEAT_CYCLES - 1);
  assign last_off  = &offset_q;
  assign end_mark  = rom_data[5:0] == 6'd0;
  // Next state: timed play walk first, then song select and enable drop override it
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    song_d   = song_q;
    offset_d = offset_q;
    note_d   = note_q;
    ent_d    = ent_q;
    beat_d   = beat_q;
    dur_d    = dur_q;
    case (state_q)
      IDLE:  state_d = play_pause ? FETCH : IDLE;
      FETCH: state_d = LOAD;
      LOAD: begin
        ent_d   = rom_data[15:6];
        note_d  = end_mark ? 10'd0 : rom_data[15:6];
        state_d = end_mark ? DONE : PLAY;
        beat_d  = '0;
        dur_d   = rom_data[5:0];
      end
      PLAY, GAP: begin
        beat_d = beat_wrap ? '0 : beat_q + 1'b1;
        dur_d  = beat_wrap ? dur_q - 6'd1 : dur_q;
        if (state_q == PLAY && dur_q == 6'd1 && beat_q == BW'(BEAT_CYCLES - GAP_CYCLES - 1)) begin
          state_d = GAP;
          note_d  = '0;
        end
        if (state_q == GAP && beat_wrap) begin
          state_d  = last_off ? DONE : FETCH;
          offset_d = last_off ? offset_q : offset_q + 1'b1;
        end
        // the pausing cycle still counts as played time; resume picks up where it would have gone
        if (play_pause) begin
          saved_d = state_d;
          state_d = PAUSED;
          note_d  = '0;
        end
      end
      PAUSED: if (play_pause) begin
        state_d = saved_q;
        note_d  = saved_q == PLAY ? ent_q : 10'd0;
      end
      DONE: if (play_pause) begin
        state_d  = FETCH;
        offset_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (next_song || prev_song) begin
      song_d   = next_song ? (song_q == SW'(NUM_SONGS - 1) ? '0 : song_q + 1'b1)
                           : (song_q == '0 ? SW'(NUM_SONGS - 1) : song_q - 1'b1);
      state_d  = IDLE;
      offset_d = '0;
      note_d   = '0;
    end
    if (!enable) begin
      song_d   = song_q;
      state_d  = IDLE;
      offset_d = '0;
      note_d   = '0;
    end
  end
  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      saved_q  <= IDLE;
      song_q   <= '0;
      offset_q <= '0;
      note_q   <= '0;
      ent_q    <= '0;
      beat_q   <= '0;
      dur_q    <= '0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      song_q   <= song_d;
      offset_q <= offset_d;
      note_q   <= note_d;
      ent_q    <= ent_d;
      beat_q   <= beat_d;
      dur_q    <= dur_d;
    end
  end
  assign rom_addr = {song_q, offset_q};
  assign note     = note_q;
  assign song_idx = song_q;
  assign playing  = state_q inside {LOAD, PLAY, GAP};
  assign done     = state_q == DONE;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: checks song_sequencer against a per-cycle note timeline built from the song ROM
module tb_song_sequencer;
  localparam int B = 10;
  localparam int G = 2;
  typedef struct packed {
    logic       done;
    logic       playing;
    logic [4:0] addr;
    logic [9:0] note;
  } obs_t;
  logic clk, rst, enable, play_pause, next_song, prev_song;
  logic [4:0] rom_addr;
  logic [15:0] rom_data;
  logic [9:0] note;
  logic [1:0] song_idx;
  logic playing, done;
  logic [15:0] rom [32];
  logic [1:0] exp_song;
  int n_chk, n_fail;

  song_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .NUM_SONGS(4), .SONG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .play_pause(play_pause),
    .next_song(next_song), .prev_song(prev_song), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .song_idx(song_idx),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;
  // ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(input logic d, input logic p, input int off, input logic [9:0] n);
    obs_t o;
    o.done    = d;
    o.playing = p;
    o.addr    = {exp_song, 3'(off)};
    o.note    = n;
    return o;
  endfunction

  task automatic test_reset();
    rst = 0;
    repeat (3) tick();
    n_chk++; if (note !== 10'd0) begin n_fail++; $display("FAIL reset_note got %h want 000", note); end
    n_chk++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %h want 00", rom_addr); end
    n_chk++; if (song_idx !== 2'd0) begin n_fail++; $display("FAIL reset_song got %0d want 0", song_idx); end
    n_chk++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got %b want 0", playing); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1;
    enable = 1;
    exp_song = 0;
    tick();
  endtask

  // Plays the current song from IDLE or DONE; pause_at: -1 none, -2 random, else observation index
  task automatic test_play(input string name, input int pause_at, input int pause_len);
    obs_t tr[$];
    bit cp[$];
    int idx[$];
    int pk;
    logic [15:0] w;
    obs_t got, pe;
    for (int i = 0; i < 8; i++) begin
      w = rom[{exp_song, 3'(i)}];
      tr.push_back(mk(0, 0, i, 0)); cp.push_back(0);
      tr.push_back(mk(0, 1, i, 0)); cp.push_back(0);
      if (w[5:0] == 6'd0) begin
        tr.push_back(mk(1, 0, i, 0)); cp.push_back(0);
        break;
      end
      for (int c = 0; c < int'(w[5:0]) * B - G; c++) begin
        tr.push_back(mk(0, 1, i, w[15:6])); cp.push_back(1);
      end
      for (int c = 0; c < G; c++) begin
        tr.push_back(mk(0, 1, i, 0)); cp.push_back(c < G - 1);
      end
      if (i == 7) begin
        tr.push_back(mk(1, 0, 7, 0)); cp.push_back(0);
      end
    end
    pk = pause_at;
    if (pause_at == -2) begin
      foreach (cp[i]) if (cp[i]) idx.push_back(i);
      pk = idx.size() > 0 ? idx[$urandom_range(0, idx.size() - 1)] : -1;
    end
    play_pause = 1;
    for (int k = 0; k < tr.size(); k++) begin
      tick();
      play_pause = 0;
      got = {done, playing, rom_addr, note};
      n_chk++;
      if (got !== tr[k]) begin
        n_fail++;
        $display("FAIL %s obs %0d: got done=%b playing=%b addr=%h note=%h, expected done=%b playing=%b addr=%h note=%h",
                 name, k, got.done, got.playing, got.addr, got.note, tr[k].done, tr[k].playing, tr[k].addr, tr[k].note);
      end
      if (k == pk) begin
        pe = tr[k];
        pe.done = 0;
        pe.playing = 0;
        pe.note = 0;
        play_pause = 1;
        for (int j = 0; j < pause_len; j++) begin
          tick();
          play_pause = 0;
          got = {done, playing, rom_addr, note};
          n_chk++;
          if (got !== pe) begin
            n_fail++;
            $display("FAIL %s paused %0d: got done=%b playing=%b addr=%h note=%h, expected paused silence at addr=%h",
                     name, j, got.done, got.playing, got.addr, got.note, pe.addr);
          end
        end
        play_pause = 1;
      end
    end
    tick();
    n_chk++;
    if (done !== 1'b1 || note !== 10'd0) begin
      n_fail++;
      $display("FAIL %s done_hold: got done=%b note=%h, expected done=1 note=000", name, done, note);
    end
  endtask

  task automatic test_song_select();
    for (int i = 0; i < 4; i++) begin
      next_song = 1; tick(); next_song = 0;
      exp_song = 2'((int'(exp_song) + 1) % 4);
      n_chk++;
      if (song_idx !== exp_song || playing !== 0 || done !== 0 || note !== 0 || rom_addr !== {exp_song, 3'd0}) begin
        n_fail++;
        $display("FAIL next_song %0d: got song=%0d addr=%h note=%h playing=%b done=%b, expected song=%0d idle", i, song_idx, rom_addr, note, playing, done, exp_song);
      end
    end
    prev_song = 1; tick(); prev_song = 0;
    exp_song = 2'((int'(exp_song) + 3) % 4);
    n_chk++;
    if (song_idx !== exp_song || rom_addr !== {exp_song, 3'd0}) begin
      n_fail++;
      $display("FAIL prev_wrap: got song=%0d addr=%h, expected song=%0d", song_idx, rom_addr, exp_song);
    end
    next_song = 1; tick(); next_song = 0;
    exp_song = 2'((int'(exp_song) + 1) % 4);
    play_pause = 1; tick(); play_pause = 0;
    repeat (5) tick();
    n_chk++;
    if (note !== 10'h001) begin n_fail++; $display("FAIL select_pre_play: got note=%h want 001", note); end
    next_song = 1; tick(); next_song = 0;
    exp_song = 2'((int'(exp_song) + 1) % 4);
    n_chk++;
    if (song_idx !== exp_song || note !== 0 || playing !== 0 || rom_addr !== {exp_song, 3'd0}) begin
      n_fail++;
      $display("FAIL select_in_play: got song=%0d addr=%h note=%h playing=%b, expected song=%0d addr=%h idle", song_idx, rom_addr, note, playing, exp_song, {exp_song, 3'd0});
    end
  endtask

  task automatic test_simultaneous();
    play_pause = 1; tick(); play_pause = 0;
    repeat (4) tick();
    n_chk++;
    if (note !== 10'h105) begin n_fail++; $display("FAIL sim_pre_play: got note=%h want 105", note); end
    next_song = 1; play_pause = 1; tick(); next_song = 0; play_pause = 0;
    exp_song = 2'((int'(exp_song) + 1) % 4);
    n_chk++;
    if (song_idx !== exp_song || note !== 0 || playing !== 0 || done !== 0 || rom_addr !== {exp_song, 3'd0}) begin
      n_fail++;
      $display("FAIL sim_select: got song=%0d addr=%h note=%h playing=%b done=%b, expected song=%0d idle", song_idx, rom_addr, note, playing, done, exp_song);
    end
  endtask

  task automatic test_enable_drop();
    play_pause = 1; tick(); play_pause = 0;
    repeat (15) tick();
    n_chk++;
    if (note === 10'd0 || rom_addr !== {exp_song, 3'd1}) begin
      n_fail++;
      $display("FAIL en_pre_play: got note=%h addr=%h, expected a note at offset 1", note, rom_addr);
    end
    enable = 0; tick();
    n_chk++;
    if (note !== 0 || playing !== 0 || done !== 0 || song_idx !== exp_song || rom_addr !== {exp_song, 3'd0}) begin
      n_fail++;
      $display("FAIL enable_drop: got song=%0d addr=%h note=%h playing=%b done=%b, expected song=%0d idle", song_idx, rom_addr, note, playing, done, exp_song);
    end
    enable = 1;
  endtask

  task automatic test_reset_mid();
    play_pause = 1; tick(); play_pause = 0;
    repeat (19) tick();
    n_chk++;
    if (note === 10'd0) begin n_fail++; $display("FAIL rst_pre_play: got note=%h, expected a note", note); end
    rst = 0; tick(); rst = 1;
    exp_song = 0;
    n_chk++;
    if (note !== 0 || rom_addr !== 0 || song_idx !== 0 || playing !== 0 || done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: got song=%0d addr=%h note=%h playing=%b done=%b, expected all zero", song_idx, rom_addr, note, playing, done);
    end
  endtask

  task automatic test_random();
    int s, m;
    for (int it = 0; it < 10; it++) begin
      s = $urandom_range(0, 3);
      while (int'(exp_song) != s) begin
        next_song = 1; tick(); next_song = 0;
        exp_song = 2'((int'(exp_song) + 1) % 4);
      end
      n_chk++;
      if (song_idx !== exp_song) begin n_fail++; $display("FAIL rand_select %0d: got song=%0d want %0d", it, song_idx, exp_song); end
      m = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++)
        rom[{exp_song, 3'(i)}] = i == m ? {10'($urandom), 6'd0} : {10'($urandom), 6'($urandom_range(1, 3))};
      test_play($sformatf("rand%0d", it), $urandom_range(0, 1) == 1 ? -2 : -1, $urandom_range(1, 20));
    end
  endtask

  initial begin
    clk = 0; rst = 0; enable = 0; play_pause = 0; next_song = 0; prev_song = 0;
    n_chk = 0; n_fail = 0; exp_song = 0;
    for (int i = 0; i < 32; i++) rom[i] = 16'd0;
    rom[0] = {10'h001, 6'd1};
    rom[1] = {10'h082, 6'd2};
    rom[8] = {10'h105, 6'd1};
    rom[9] = {10'h203, 6'd1};
    for (int i = 0; i < 8; i++) rom[16 + i] = {10'(8'h11 * (i + 1)), 6'd1};
    test_reset();
    test_play("basic", -1, 0);
    test_play("pause_resume", 18, 50);
    test_song_select();
    test_simultaneous();
    test_play("offset_wrap", -1, 0);
    test_enable_drop();
    test_play("reenable", -1, 0);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Play-mode note source. Walks a song ROM entry by entry, holds each note for its encoded number of beats, and inserts a short silent gap between notes. It supports play/pause and song selection. It sits between the song memory and the buzzer-controller `DATABASE_Note` input, is gated by the play-mode `databaseEnable`, and takes play/pause and song-select pulses from the debounced WASDE stage.

## Interface
Parameters:
- `BEAT_CYCLES`, default 25_000_000: clock cycles per beat (250 ms at 100 MHz).
- `GAP_CYCLES`, default 1_000_000: silent cycles at the end of each note. Legal range is 1 ≤ GAP_CYCLES < BEAT_CYCLES.
- `NUM_SONGS`, default 4: number of selectable songs (≥2).
- `SONG_ADDR_W`, default 8: per-song entry address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `enable`  in  1  play mode active (`databaseEnable`).
- `play_pause`  in  1  one-cycle pulse: start / pause / resume / restart.
- `next_song`  in  1  one-cycle pulse: select the next song.
- `prev_song`  in  1  one-cycle pulse: select the previous song.
- `rom_addr`  out  clog2(NUM_SONGS)+SONG_ADDR_W  registered, equal to {song_idx, offset}.
- `rom_data`  in  16  ROM word, valid exactly 1 cycle after `rom_addr` changes.
- `note`  out  10  registered note in Pin_Note encoding ([6:0] note one-hot, [9:7] pitch); 0 means silence.
- `song_idx`  out  clog2(NUM_SONGS)  current song.
- `playing`  out  1  high in the LOAD, PLAY and GAP states.
- `done`  out  1  high in the DONE state.

## Operation
ROM word format:
- [15:6] is the note.
- [5:0] is the duration in beats.
- A duration of 0 is the end-of-song marker; its note field is ignored.

States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE.
- **IDLE:** `note`=0 and offset=0. On `play_pause` with `enable` high, go to FETCH.
- **FETCH:** `rom_addr` holds {song_idx, offset}. Go to LOAD next cycle.
- **LOAD:** capture `rom_data`.
  - If duration is 0, go to DONE.
  - Otherwise `note` ← [15:6], beat_cnt ← 0, dur_cnt ← duration, and go to PLAY.
- **PLAY:** beat_cnt counts 0..BEAT_CYCLES-1 and dur_cnt decrements at each beat wrap. When the remaining time for the entry equals GAP_CYCLES, go to GAP.
- **GAP:** `note`=0 for GAP_CYCLES cycles. Then:
  - If offset = 2^SONG_ADDR_W−1, go to DONE (wrap is treated as end of song).
  - Otherwise offset ← offset+1 and go to FETCH.
- **PAUSED:**
  - Entered on `play_pause` in PLAY or GAP. The state being left is saved.
  - `note`=0; beat_cnt, dur_cnt and offset are frozen.
  - The next `play_pause` returns to the saved state. If that state is PLAY, `note` is restored from the latched entry.
- **DONE:** `note`=0 and `done`=1. On `play_pause`, offset ← 0 and go to FETCH (replay).
- **Song select:** `next_song` / `prev_song` in any state set song_idx to (song_idx ± 1) mod NUM_SONGS, then offset ← 0, `note` ← 0, and go to IDLE.
- **Priority, highest first:**
  1. `rst`
  2. `enable` low
  3. `next_song`
  4. `prev_song`
  5. `play_pause`
  - Lower-priority pulses in the same cycle are dropped.
- **`enable` low:** forced to IDLE the same edge. offset=0, `note`=0, and song_idx is retained.
- `play_pause` in FETCH or LOAD is ignored.

## Timing
- **Reset values:**
  - state = IDLE.
  - `note`=0, `rom_addr`=0, `song_idx`=0, `playing`=0, `done`=0.
  - All counters are 0.
  - Reset mid-song aborts immediately with no gap.
- **Per-entry period:** 2 + dur×BEAT_CYCLES cycles.
  - FETCH is 1 cycle and LOAD is 1 cycle.
  - `note` is nonzero for dur×BEAT_CYCLES − GAP_CYCLES cycles.
  - `note` is zero for GAP_CYCLES cycles.
- **First note:** `note` is nonzero on the 3rd edge after the cycle in which `play_pause` is sampled in IDLE (IDLE→FETCH→LOAD→PLAY).
- **Pause:** `note` goes to 0 one edge after the `play_pause` sample. On resume, the remaining duration is exactly what was left at pause time.
- **Duration width:** dur_cnt is 6 bits. Max entry length is 63 beats. The product dur×BEAT_CYCLES is never formed; the beat and duration counters run separately.
- **Outputs:** all outputs are registered with no combinational path from inputs.

## Test plan
Common setup: BEAT_CYCLES=10, GAP_CYCLES=2, NUM_SONGS=4, SONG_ADDR_W=3, and a behavioral ROM with 1-cycle latency.

1. **Basic song.** Song 0 = {0x001/dur 1, 0x082/dur 2, end}. Pulse `play_pause`.
   - `note`=0x001 for 8 cycles, then 0 for 2 cycles.
   - 2 cycles later, `note`=0x082 for 18 cycles, then 0 for 2 cycles.
   - Then `done`=1.
   - Total from pulse to `done` is 36 cycles.
2. **Pause / resume.** Pause 5 cycles into the 0x082 note and hold 50 cycles.
   - `note`=0 and `playing`=0 during the pause.
   - After resume, `note`=0x082 for exactly 13 more cycles, then the gap.
3. **Song select and wrap.**
   - `next_song` ×4 returns `song_idx` to 0.
   - `prev_song` from 0 gives 3.
   - `next_song` during PLAY drops to IDLE, `note`=0, and `rom_addr`={new idx, 0}.
4. **Simultaneous events and enable drop.**
   - `next_song` together with `play_pause` in PLAY: the song changes and the block goes to IDLE, not PAUSED.
   - `enable` low mid-note: IDLE next edge, `note`=0, song index kept.
   - Re-enable plus `play_pause` starts from offset 0.
5. **Offset wrap and reset.**
   - A song with 8 nonzero entries and no marker: after the entry at offset 7 the block enters DONE with no 9th fetch.
   - `rst` low mid-note: all outputs match their reset values after the next edge.
   - `play_pause` from DONE replays from offset 0.
